mem_port_arbiter: RTL

//  Shares one single-port memory between the CPU instruction bus (I) and data bus (D).

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the I/D memory port arbiter: FSM state encodings,
//   grant codes, the latched access record and a small saturating helper.
package mem_port_arbiter_pkg;

    // FSM state encodings (legacy-compatible constants)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Grant codes: which port owns the current access
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Access fields captured from the winning port in IDLE
    typedef struct packed {
        logic        write;
        logic [3:0]  byteEnable;
        logic [31:0] address;
        logic [31:0] writeData;
    } memAccess_t;

    // 4-bit increment that sticks at all-ones
    function automatic logic [3:0] satInc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the CPU instruction (I) and data (D)
//   buses. Accesses are serialised through IDLE -> BUSY -> DONE; the granted
//   port receives a one-cycle ready pulse and, for reads, registered read data.
//   D wins simultaneous requests unless I has waited through MAX_DCONSEC
//   consecutive D grants.
// Ports
//   iCLK, iRST                 clock, synchronous active-high reset
//   iI*/oI*                    instruction port request fields, read data, ready
//   iD*/oD*                    data port request fields, read data, ready
//   oM*/iMReadData             memory-side strobes, address, data
//   oStall                     core stall: a request is pending without ready
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned MAX_DCONSEC = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic        iIWrite,
    input  logic [3:0]  iIByteEnable,
    input  logic [31:0] iIAddress,
    input  logic [31:0] iIWriteData,
    output logic [31:0] oIReadData,
    output logic        oIReady,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic [31:0] oDReadData,
    output logic        oDReady,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    output logic        oStall
);

    localparam logic [3:0] LAST_CNT  = 4'(MEM_LAT - 1);
    localparam logic [3:0] DCNT_LIMIT = 4'(MAX_DCONSEC);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  dcnt;
    logic        gnt;
    memAccess_t  access;
    logic [31:0] iReadData;
    logic [31:0] dReadData;

    logic        grantD;
    logic        busy;
    logic        done;

    // D has priority unless I has been starved for MAX_DCONSEC D grants
    assign grantD = iDReq & ~(iIReq & (dcnt == DCNT_LIMIT));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            gnt       <= GNT_I;
            access    <= '0;
            iReadData <= '0;
            dReadData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Starvation count only tracks D grants made while I waits
                    if (!iIReq)
                        dcnt <= '0;
                    else if (grantD)
                        dcnt <= satInc4(dcnt);
                    else
                        dcnt <= '0;

                    if (iIReq || iDReq) begin
                        cnt   <= '0;
                        state <= ST_BUSY;
                        if (grantD) begin
                            gnt    <= GNT_D;
                            access <= '{write: iDWrite, byteEnable: iDByteEnable,
                                        address: iDAddress, writeData: iDWriteData};
                        end else begin
                            gnt    <= GNT_I;
                            access <= '{write: iIWrite, byteEnable: iIByteEnable,
                                        address: iIAddress, writeData: iIWriteData};
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        if (!access.write) begin
                            if (gnt == GNT_D)
                                dReadData <= iMReadData;
                            else
                                iReadData <= iMReadData;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    // Memory side is quiet outside BUSY; a write strobes only on its first cycle
    assign oMReadEnable  = busy & ~access.write;
    assign oMWriteEnable = busy & access.write & (cnt == 4'd0);
    assign oMByteEnable  = busy ? access.byteEnable : '0;
    assign oMAddress     = busy ? access.address    : '0;
    assign oMWriteData   = busy ? access.writeData  : '0;

    assign oIReady    = done & (gnt == GNT_I);
    assign oDReady    = done & (gnt == GNT_D);
    assign oIReadData = iReadData;
    assign oDReadData = dReadData;

    assign oStall = (iIReq & ~oIReady) | (iDReq & ~oDReady);

endmodule
